// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM scanout arbiter: FSM encoding, read-return
// source tags and default parameter values.
package vram_pkg;

   localparam int unsigned DEF_ROW_WORDS = 512;
   localparam int unsigned DEF_ADDR_W    = 18;
   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_READ_LAT  = 2;
   localparam logic [31:0] DEF_FB0_BASE  = 32'h0000_0000;
   localparam logic [31:0] DEF_FB1_BASE  = 32'h0002_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_ROW = 1'b0,
      SRC_RND = 1'b1
   } rd_src_t;

   // Width of a counter able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vram_read_tag_pipe.sv
// Fixed-latency shift register carrying a tag alongside each VRAM read so the
// returning data can be routed to the row buffer or the renderer.
module vram_read_tag_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 10
) (
   input  logic             i_master_clk,
   input  logic             i_reset,
   input  logic             i_push_valid,
   input  logic [TAG_W-1:0] i_push_tag,
   output logic             o_pop_valid,
   output logic [TAG_W-1:0] o_pop_tag
);

   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [DEPTH];

   always_ff @(posedge i_master_clk) begin
      if (i_reset) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= i_push_valid;
         tag_q[0]   <= i_push_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   // Gated so nothing already in flight can surface while reset is held.
   assign o_pop_valid = valid_q[DEPTH-1] & ~i_reset;
   assign o_pop_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/vram_scanout_arbiter.sv
// Arbitrates a single VRAM port between display row prefetch bursts and the
// renderer, and manages front/back frame-buffer flipping.
module vram_scanout_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned       ROW_WORDS = DEF_ROW_WORDS,
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter int unsigned       READ_LAT  = DEF_READ_LAT,
   parameter logic [ADDR_W-1:0] FB0_BASE  = ADDR_W'(DEF_FB0_BASE),
   parameter logic [ADDR_W-1:0] FB1_BASE  = ADDR_W'(DEF_FB1_BASE)
) (
   input  logic                         i_master_clk,
   input  logic                         i_reset,
   input  logic                         i_prefetch_start,
   input  logic                         i_row_first,
   input  logic                         i_row_last,
   input  logic                         i_switch_allowed,
   input  logic                         i_swap_request,
   output logic                         o_front_buffer,
   output logic                         o_swap_done,
   input  logic                         i_rnd_valid,
   input  logic                         i_rnd_write,
   input  logic [ADDR_W-1:0]            i_rnd_addr,
   input  logic [DATA_W-1:0]            i_rnd_wdata,
   output logic                         o_rnd_ready,
   output logic [DATA_W-1:0]            o_rnd_rdata,
   output logic                         o_rnd_rdata_valid,
   output logic                         o_mem_en,
   output logic                         o_mem_we,
   output logic [ADDR_W-1:0]            o_mem_addr,
   output logic [DATA_W-1:0]            o_mem_wdata,
   input  logic [DATA_W-1:0]            i_mem_rdata,
   output logic                         o_row_wvalid,
   output logic [$clog2(ROW_WORDS)-1:0] o_row_waddr,
   output logic [DATA_W-1:0]            o_row_wdata,
   output logic                         o_overrun
);

   localparam int unsigned RA_W  = $clog2(ROW_WORDS);
   localparam int unsigned DL_W  = cnt_width(READ_LAT);
   localparam int unsigned TAG_W = RA_W + 1;

   localparam logic [RA_W-1:0] LAST_WORD  = RA_W'(ROW_WORDS - 1);
   localparam logic [DL_W-1:0] LAST_DRAIN = DL_W'(READ_LAT - 1);

   arb_state_t state_q, state_d;

   logic [ADDR_W-1:0] row_ptr_q;
   logic              frame_active_q;
   logic              final_q;
   logic [RA_W-1:0]   word_cnt_q;
   logic [DL_W-1:0]   drain_cnt_q;

   logic front_q, pending_q, swap_done_q, overrun_q;

   logic start_burst, burst_issue, last_issue;
   logic rnd_ready, rnd_accept;
   logic mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   logic             tag_push;
   rd_src_t          push_src;
   logic [RA_W-1:0]  push_idx;
   logic [TAG_W-1:0] tag_in, tag_out;
   logic             tag_pop;
   rd_src_t          pop_src;

   always_ff @(posedge i_master_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      start_burst = 1'b0;
      burst_issue = 1'b0;
      last_issue  = 1'b0;
      rnd_ready   = 1'b0;
      rnd_accept  = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      tag_push    = 1'b0;
      push_src    = SRC_ROW;
      push_idx    = '0;

      case (state_q)
         ST_IDLE: begin
            if (i_prefetch_start && (frame_active_q || i_row_first)) begin
               state_d     = ST_BURST;
               start_burst = 1'b1;
            end
            // Prefetch owns the port in a tie, even if it turns out not to start.
            rnd_ready  = ~i_prefetch_start;
            rnd_accept = rnd_ready & i_rnd_valid;
         end
         ST_BURST: begin
            burst_issue = 1'b1;
            if (word_cnt_q == LAST_WORD) begin
               last_issue = 1'b1;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == LAST_DRAIN) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (i_reset) begin
         rnd_ready   = 1'b0;
         rnd_accept  = 1'b0;
         burst_issue = 1'b0;
      end

      if (burst_issue) begin
         mem_en   = 1'b1;
         mem_addr = row_ptr_q + ADDR_W'(word_cnt_q);
         tag_push = 1'b1;
         push_src = SRC_ROW;
         push_idx = word_cnt_q;
      end else if (rnd_accept) begin
         mem_en   = 1'b1;
         mem_we   = i_rnd_write;
         mem_addr = i_rnd_addr;
         if (i_rnd_write) begin
            mem_wdata = i_rnd_wdata;
         end else begin
            tag_push = 1'b1;
            push_src = SRC_RND;
         end
      end
   end

   always_ff @(posedge i_master_clk) begin
      if (i_reset) begin
         row_ptr_q      <= FB0_BASE;
         frame_active_q <= 1'b0;
         final_q        <= 1'b0;
         word_cnt_q     <= '0;
         drain_cnt_q    <= '0;
      end else begin
         // A row_first pulse reloads the pointer from the buffer on screen now,
         // so a flip mid-frame only shows up at the start of the next frame.
         if (state_q == ST_IDLE && i_prefetch_start && i_row_first) begin
            row_ptr_q      <= front_q ? FB1_BASE : FB0_BASE;
            frame_active_q <= 1'b1;
         end
         if (start_burst) begin
            final_q    <= i_row_last;
            word_cnt_q <= '0;
         end
         if (burst_issue) begin
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (last_issue) begin
            row_ptr_q   <= row_ptr_q + ADDR_W'(ROW_WORDS);
            drain_cnt_q <= '0;
            if (final_q) begin
               frame_active_q <= 1'b0;
            end
         end
         if (state_q == ST_DRAIN) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_master_clk) begin
      if (i_reset) begin
         front_q     <= 1'b0;
         pending_q   <= 1'b0;
         swap_done_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         swap_done_q <= 1'b0;
         if (i_switch_allowed && (pending_q || i_swap_request)) begin
            front_q     <= ~front_q;
            swap_done_q <= 1'b1;
            pending_q   <= 1'b0;
         end else if (i_swap_request) begin
            pending_q <= 1'b1;
         end
         if (i_prefetch_start && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign tag_in = {push_src, push_idx};

   vram_read_tag_pipe #(
      .DEPTH (READ_LAT),
      .TAG_W (TAG_W)
   ) u_tag_pipe (
      .i_master_clk (i_master_clk),
      .i_reset      (i_reset),
      .i_push_valid (tag_push),
      .i_push_tag   (tag_in),
      .o_pop_valid  (tag_pop),
      .o_pop_tag    (tag_out)
   );

   assign pop_src = rd_src_t'(tag_out[TAG_W-1]);

   assign o_row_wvalid      = tag_pop & (pop_src == SRC_ROW);
   assign o_row_waddr       = tag_out[RA_W-1:0];
   assign o_row_wdata       = i_mem_rdata;
   assign o_rnd_rdata_valid = tag_pop & (pop_src == SRC_RND);
   assign o_rnd_rdata       = i_mem_rdata;

   assign o_rnd_ready = rnd_ready;
   assign o_mem_en    = mem_en;
   assign o_mem_we    = mem_we;
   assign o_mem_addr  = mem_addr;
   assign o_mem_wdata = mem_wdata;

   assign o_front_buffer = front_q & ~i_reset;
   assign o_swap_done    = swap_done_q & ~i_reset;
   assign o_overrun      = overrun_q & ~i_reset;

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Scoreboard bench: stimulus predicts VRAM accesses, read returns and status
// outputs from the arbitration rules; a negedge monitor consumes them.
module tb_vram_scanout_arbiter;

   localparam int unsigned ROW_WORDS = 512;
   localparam int unsigned ADDR_W    = 18;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned READ_LAT  = 2;
   localparam int unsigned FB0       = 32'h0;
   localparam int unsigned FB1       = 32'h20000;
   localparam int unsigned RA_W      = $clog2(ROW_WORDS);
   localparam int unsigned ADDR_MASK = (1 << ADDR_W) - 1;

   logic                i_master_clk = 1'b0;
   logic                i_reset = 1'b1;
   logic                i_prefetch_start = 1'b0;
   logic                i_row_first = 1'b0;
   logic                i_row_last = 1'b0;
   logic                i_switch_allowed = 1'b0;
   logic                i_swap_request = 1'b0;
   logic                o_front_buffer, o_swap_done;
   logic                i_rnd_valid = 1'b0;
   logic                i_rnd_write = 1'b0;
   logic [ADDR_W-1:0]   i_rnd_addr = '0;
   logic [DATA_W-1:0]   i_rnd_wdata = '0;
   logic                o_rnd_ready;
   logic [DATA_W-1:0]   o_rnd_rdata;
   logic                o_rnd_rdata_valid;
   logic                o_mem_en, o_mem_we;
   logic [ADDR_W-1:0]   o_mem_addr;
   logic [DATA_W-1:0]   o_mem_wdata;
   logic [DATA_W-1:0]   i_mem_rdata;
   logic                o_row_wvalid;
   logic [RA_W-1:0]     o_row_waddr;
   logic [DATA_W-1:0]   o_row_wdata;
   logic                o_overrun;

   vram_scanout_arbiter #(
      .ROW_WORDS (ROW_WORDS),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .READ_LAT  (READ_LAT),
      .FB0_BASE  (ADDR_W'(FB0)),
      .FB1_BASE  (ADDR_W'(FB1))
   ) dut (
      .i_master_clk      (i_master_clk),
      .i_reset           (i_reset),
      .i_prefetch_start  (i_prefetch_start),
      .i_row_first       (i_row_first),
      .i_row_last        (i_row_last),
      .i_switch_allowed  (i_switch_allowed),
      .i_swap_request    (i_swap_request),
      .o_front_buffer    (o_front_buffer),
      .o_swap_done       (o_swap_done),
      .i_rnd_valid       (i_rnd_valid),
      .i_rnd_write       (i_rnd_write),
      .i_rnd_addr        (i_rnd_addr),
      .i_rnd_wdata       (i_rnd_wdata),
      .o_rnd_ready       (o_rnd_ready),
      .o_rnd_rdata       (o_rnd_rdata),
      .o_rnd_rdata_valid (o_rnd_rdata_valid),
      .o_mem_en          (o_mem_en),
      .o_mem_we          (o_mem_we),
      .o_mem_addr        (o_mem_addr),
      .o_mem_wdata       (o_mem_wdata),
      .i_mem_rdata       (i_mem_rdata),
      .o_row_wvalid      (o_row_wvalid),
      .o_row_waddr       (o_row_waddr),
      .o_row_wdata       (o_row_wdata),
      .o_overrun         (o_overrun)
   );

   always #5 i_master_clk = ~i_master_clk;

   int unsigned cyc = 0;
   always @(posedge i_master_clk) cyc <= cyc + 1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
      return DATA_W'((a * 32'd40503) ^ 32'h5A5A);
   endfunction

   // Environment VRAM: fixed READ_LAT pipeline, updated by what the DUT drives.
   logic [DATA_W-1:0] vram [int unsigned];
   logic [DATA_W-1:0] rd_pipe [READ_LAT];

   function automatic logic [DATA_W-1:0] vram_rd(input int unsigned a);
      return vram.exists(a) ? vram[a] : init_word(a);
   endfunction

   always @(posedge i_master_clk) begin
      if (o_mem_en && o_mem_we) vram[int'(o_mem_addr)] = o_mem_wdata;
      rd_pipe[0] <= (o_mem_en && !o_mem_we) ? vram_rd(int'(o_mem_addr)) : '0;
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign i_mem_rdata = rd_pipe[READ_LAT-1];

   // Reference memory contents as the renderer should have left them.
   logic [DATA_W-1:0] ref_mem [int unsigned];

   function automatic logic [DATA_W-1:0] ref_rd(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   typedef struct {
      int unsigned       cyc;
      bit                we;
      int unsigned       addr;
      logic [DATA_W-1:0] wdata;
      bit                row;
      int unsigned       idx;
      logic [DATA_W-1:0] data;
   } acc_t;

   typedef struct {
      int unsigned       due;
      bit                row;
      int unsigned       idx;
      logic [DATA_W-1:0] data;
   } ret_t;

   acc_t exp_acc[$];
   ret_t exp_ret[$];

   // Behavioural state of the arbiter as seen from its ports.
   int unsigned busy_until = 0;
   bit          active = 0;
   int unsigned ptr = FB0;
   bit          pending = 0;
   bit          front_cur = 0, front_nxt = 0;
   bit          done_cur = 0, done_nxt = 0;
   bit          ov_cur = 0, ov_nxt = 0;
   bit          ready_exp = 0;

   bit                rq_valid = 0;
   bit                rq_we = 0;
   int unsigned       rq_addr = 0;
   logic [DATA_W-1:0] rq_wdata = '0;

   task automatic step(input bit pf, input bit first, input bit last,
                       input bit sw, input bit req, input bit rst);
      bit   idle;
      acc_t a;
      @(posedge i_master_clk);
      #1;
      i_prefetch_start = pf;
      i_row_first      = first;
      i_row_last       = last;
      i_switch_allowed = sw;
      i_swap_request   = req;
      i_reset          = rst;
      i_rnd_valid      = rq_valid;
      i_rnd_write      = rq_we;
      i_rnd_addr       = ADDR_W'(rq_addr);
      i_rnd_wdata      = rq_wdata;
      front_cur = front_nxt;
      done_cur  = done_nxt;
      ov_cur    = ov_nxt;
      if (rst) begin
         exp_acc.delete();
         busy_until = 0;
         active     = 0;
         ptr        = FB0;
         pending    = 0;
         front_cur  = 0; front_nxt = 0;
         done_cur   = 0; done_nxt  = 0;
         ov_cur     = 0; ov_nxt    = 0;
         ready_exp  = 0;
      end else begin
         idle      = (cyc >= busy_until);
         done_nxt  = 0;
         ready_exp = idle && !pf;
         if (pf && !idle) begin
            ov_nxt = 1;
         end else if (pf) begin
            if (first) begin
               ptr    = front_cur ? FB1 : FB0;
               active = 1;
            end
            if (active) begin
               for (int unsigned i = 0; i < ROW_WORDS; i++) begin
                  a.cyc   = cyc + 1 + i;
                  a.we    = 0;
                  a.addr  = (ptr + i) & ADDR_MASK;
                  a.wdata = '0;
                  a.row   = 1;
                  a.idx   = i;
                  a.data  = ref_rd(a.addr);
                  exp_acc.push_back(a);
               end
               ptr        = (ptr + ROW_WORDS) & ADDR_MASK;
               busy_until = cyc + 1 + ROW_WORDS + READ_LAT;
               if (last) active = 0;
            end
         end
         if (rq_valid && ready_exp) begin
            a.cyc   = cyc;
            a.we    = rq_we;
            a.addr  = rq_addr;
            a.wdata = rq_wdata;
            a.row   = 0;
            a.idx   = 0;
            a.data  = ref_rd(rq_addr);
            exp_acc.push_back(a);
            if (rq_we) ref_mem[rq_addr] = rq_wdata;
            rq_valid = 0;
         end
         if (sw && (pending || req)) begin
            front_nxt = !front_cur;
            done_nxt  = 1;
            pending   = 0;
         end else if (req) begin
            pending = 1;
         end
      end
   endtask

   task automatic idle_cycles(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic rnd_req(input bit we, input int unsigned addr, input logic [DATA_W-1:0] wd);
      rq_valid = 1;
      rq_we    = we;
      rq_addr  = addr;
      rq_wdata = wd;
   endtask

   always @(negedge i_master_clk) begin : monitor
      ret_t r;
      acc_t a;
      chk("rnd_ready", 32'(o_rnd_ready), 32'(ready_exp));
      chk("front_buffer", 32'(o_front_buffer), 32'(front_cur));
      chk("swap_done", 32'(o_swap_done), 32'(done_cur));
      chk("overrun", 32'(o_overrun), 32'(ov_cur));
      if (i_reset) begin
         exp_ret.delete();
         chk("mem_en_in_reset", 32'(o_mem_en), 0);
         chk("row_wvalid_in_reset", 32'(o_row_wvalid), 0);
         chk("rdata_valid_in_reset", 32'(o_rnd_rdata_valid), 0);
      end else begin
         if (exp_ret.size() > 0 && exp_ret[0].due == cyc) begin
            r = exp_ret.pop_front();
            chk("row_wvalid", 32'(o_row_wvalid), 32'(r.row));
            chk("rnd_rdata_valid", 32'(o_rnd_rdata_valid), 32'(!r.row));
            if (r.row) begin
               chk("row_waddr", 32'(o_row_waddr), r.idx);
               chk("row_wdata", 32'(o_row_wdata), 32'(r.data));
            end else begin
               chk("rnd_rdata", 32'(o_rnd_rdata), 32'(r.data));
            end
         end else begin
            chk("row_wvalid_unexpected", 32'(o_row_wvalid), 0);
            chk("rnd_rdata_valid_unexpected", 32'(o_rnd_rdata_valid), 0);
         end
         if (exp_acc.size() > 0 && exp_acc[0].cyc == cyc) begin
            a = exp_acc.pop_front();
            chk("mem_en", 32'(o_mem_en), 1);
            chk("mem_we", 32'(o_mem_we), 32'(a.we));
            chk("mem_addr", 32'(o_mem_addr), a.addr);
            if (a.we) begin
               chk("mem_wdata", 32'(o_mem_wdata), 32'(a.wdata));
            end else begin
               r.due  = cyc + READ_LAT;
               r.row  = a.row;
               r.idx  = a.idx;
               r.data = a.data;
               exp_ret.push_back(r);
            end
         end else begin
            chk("mem_en_unexpected", 32'(o_mem_en), 0);
         end
      end
   end

   initial begin
      int unsigned guard;

      // Reset, then idle
      repeat (3) step(0, 0, 0, 0, 0, 1);
      idle_cycles(3);

      // Renderer read at 'h100, then write/read-back
      rnd_req(0, 'h100, '0);
      idle_cycles(4);
      rnd_req(1, 'h10, 16'hBEEF);
      step(0, 0, 0, 0, 0, 0);
      rnd_req(0, 'h10, '0);
      idle_cycles(4);

      // First row from buffer 0; renderer held off; second start mid-burst
      step(1, 1, 0, 0, 0, 0);
      rnd_req(0, 'h20, '0);
      idle_cycles(50);
      step(1, 0, 0, 0, 0, 0);
      idle_cycles(470);

      // Continuing rows, then last row, then a start with no frame active
      step(1, 0, 0, 0, 0, 0);
      idle_cycles(520);
      step(1, 0, 1, 0, 0, 0);
      idle_cycles(520);
      step(1, 0, 0, 0, 0, 0);
      idle_cycles(5);

      // Same-cycle swap; empty switch; collapsed requests; flip again
      step(0, 0, 0, 1, 1, 0);
      idle_cycles(2);
      step(0, 0, 0, 1, 0, 0);
      idle_cycles(2);
      repeat (3) step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      idle_cycles(2);
      step(0, 0, 0, 1, 1, 0);
      idle_cycles(2);

      // New frame from buffer 1; flip mid-frame must not move the pointer
      step(1, 1, 0, 0, 0, 0);
      idle_cycles(520);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      idle_cycles(2);
      step(1, 0, 1, 0, 0, 0);
      idle_cycles(520);

      // Reset at burst word 100
      step(1, 1, 0, 0, 0, 0);
      idle_cycles(100);
      step(0, 0, 0, 0, 0, 1);
      idle_cycles(5);
      step(1, 0, 0, 0, 0, 0);
      idle_cycles(5);

      // Randomised traffic
      for (int unsigned i = 0; i < 5000; i++) begin
         if (!rq_valid && ($urandom_range(3) == 0)) begin
            rnd_req(1'($urandom_range(1)),
                    ($urandom_range(3) == 0) ? (FB1 + $urandom_range(1023)) : $urandom_range(1535),
                    DATA_W'($urandom));
         end
         step($urandom_range(249) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
              $urandom_range(39) == 0, $urandom_range(29) == 0, $urandom_range(1999) == 0);
      end

      // Drain outstanding work with a bounded wait
      rq_valid = 0;
      guard = 0;
      while ((exp_acc.size() > 0 || exp_ret.size() > 0 || cyc < busy_until) && guard < 3000) begin
         step(0, 0, 0, 0, 0, 0);
         guard++;
      end
      checks++;
      if (guard >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending accesses %0d pending returns expected 0",
                  exp_acc.size(), exp_ret.size());
      end
      idle_cycles(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
